// File: rtl/des_key_schedule_seq_if.sv
// Handshake bundle for the sequential DES key schedule: key input channel and subkey output channel.
// The block itself uses the slave modport; the key source / subkey consumer side uses master.
interface des_key_schedule_seq_if;
  logic [63:0] key_in;
  logic        key_valid;
  logic        key_ready;
  logic [47:0] subkey_out;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  subkey_idx;
  logic        subkey_last;

  modport master (
    output key_in, key_valid, subkey_ready,
    input  key_ready, subkey_out, subkey_valid, subkey_idx, subkey_last
  );

  modport slave (
    input  key_in, key_valid, subkey_ready,
    output key_ready, subkey_out, subkey_valid, subkey_idx, subkey_last
  );
endinterface

// File: rtl/des_key_schedule_seq.sv
// Sequential DES key schedule: PC-1 on key accept, per-round C/D rotation, one PC-2 subkey per handshake.
// Optional macro DES_KEYSCHED_DECRYPT_EN adds a decrypt input that emits K16..K1 by rotating right.
module des_key_schedule_seq #(
  parameter bit PC1_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef DES_KEYSCHED_DECRYPT_EN
  input  logic                  decrypt,
`endif
  des_key_schedule_seq_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // DES bit n of an N-bit vector lives at index N-n (bit 1 is the MSB).
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
    return r;
  endfunction

  function automatic logic [1:0] shift_amt(input logic [3:0] r);
    return ((r == 4'd0) || (r == 4'd1) || (r == 4'd8) || (r == 4'd15)) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] h, input logic [1:0] n, input logic right);
    logic [27:0] r;
    case (n)
      2'd1:    r = right ? {h[0], h[27:1]}   : {h[26:0], h[27]};
      2'd2:    r = right ? {h[1:0], h[27:2]} : {h[25:0], h[27:26]};
      default: r = h;
    endcase
    return r;
  endfunction

  function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic [1:0] n, input logic right);
    return {rot28(cd[55:28], n, right), rot28(cd[27:0], n, right)};
  endfunction

  state_t      state_p0, state_nxt;
  logic [55:0] cd_p0, cd0_p0, cd_load, cd_nxt;
  logic [3:0]  round_p0;
  logic        dec_p0;
  logic [1:0]  shamt;
  logic        key_acc, sub_acc;

  logic        key_ready_c, subkey_valid_c, subkey_last_c;
  logic [47:0] subkey_out_c;
  logic [3:0]  subkey_idx_c;

  assign cd_load = PC1_EN ? pc1(bus.key_in) : bus.key_in[55:0];

  // Decrypt starts from {C0,D0} unrotated, then undoes the encrypt shifts in reverse order.
  always_comb begin
    if (dec_p0) shamt = (round_p0 == 4'd0) ? 2'd0 : shift_amt(4'(4'd0 - round_p0));
    else        shamt = shift_amt(round_p0);
    cd_nxt = rot_cd(cd_p0, shamt, dec_p0);
  end

  always_comb begin
    state_nxt      = state_p0;
    key_ready_c    = 1'b0;
    subkey_valid_c = 1'b0;
    subkey_out_c   = '0;
    subkey_idx_c   = '0;
    subkey_last_c  = 1'b0;
    key_acc        = 1'b0;
    sub_acc        = 1'b0;
    case (state_p0)
      IDLE: begin
        key_ready_c = 1'b1;
        key_acc     = bus.key_valid;
        if (bus.key_valid) state_nxt = RUN;
      end
      RUN: begin
        subkey_valid_c = 1'b1;
        subkey_out_c   = pc2(cd_nxt);
        subkey_idx_c   = round_p0;
        subkey_last_c  = (round_p0 == 4'd15);
        sub_acc        = bus.subkey_ready;
        if (bus.subkey_ready && (round_p0 == 4'd15)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.key_ready    = key_ready_c;
  assign bus.subkey_valid = subkey_valid_c;
  assign bus.subkey_out   = subkey_out_c;
  assign bus.subkey_idx   = subkey_idx_c;
  assign bus.subkey_last  = subkey_last_c;

  // Stage p0: key-schedule state; round wraps 15 -> 0 on the final handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      cd_p0    <= '0;
      cd0_p0   <= '0;
      round_p0 <= '0;
    end else begin
      state_p0 <= state_nxt;
      if (key_acc) begin
        cd_p0    <= cd_load;
        cd0_p0   <= cd_load;
        round_p0 <= '0;
      end else if (sub_acc) begin
        cd_p0    <= cd_nxt;
        round_p0 <= round_p0 + 4'd1;
        if (round_p0 == 4'd15)
          assert (cd_nxt == (dec_p0 ? rot_cd(cd0_p0, 2'd1, 1'b0) : cd0_p0));
      end
    end
  end

`ifdef DES_KEYSCHED_DECRYPT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       dec_p0 <= 1'b0;
    else if (key_acc) dec_p0 <= decrypt;
  end
`else
  assign dec_p0 = 1'b0;
`endif

endmodule
